// File: rtl/park_space_allocator_if.sv
// Entry/exit request and status bundle for the parking space allocator.
interface park_space_allocator_if #(
   parameter int unsigned SPACES = 8,
   parameter int unsigned IDX_W  = 3
) ();

   logic              entry_req;
   logic              exit_req;
   logic [IDX_W-1:0]  exit_space;
   logic              entry_grant;
   logic              entry_deny;
   logic [IDX_W-1:0]  park_number;
   logic              gate_open;
   logic [SPACES-1:0] occupancy;
   logic [IDX_W:0]    free_count;
   logic              full;
   logic              exit_err;

   // Gate sensors / controller side
   modport master (
      output entry_req, exit_req, exit_space,
      input  entry_grant, entry_deny, park_number, gate_open,
             occupancy, free_count, full, exit_err
   );

   // Allocator side
   modport slave (
      input  entry_req, exit_req, exit_space,
      output entry_grant, entry_deny, park_number, gate_open,
             occupancy, free_count, full, exit_err
   );

endinterface

// File: rtl/park_space_allocator.sv
// Parking space allocator: registered occupancy map, lowest-free-space
// allocation with grant/deny handshake, exit handling and a timed entry gate.
module park_space_allocator #(
   parameter int unsigned SPACES      = 8,
   parameter int unsigned IDX_W       = 3,
   parameter int unsigned GATE_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   park_space_allocator_if.slave  bus
);

   localparam int unsigned FREE_W = IDX_W + 1;
   localparam int unsigned CNT_W  = $clog2(GATE_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ALLOC    = 3'd1,
      GATE     = 3'd2,
      DENY     = 3'd3,
      WAIT_REL = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [SPACES-1:0] occ_q, occ_d;
   logic [IDX_W-1:0]  park_q, park_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              grant_q, grant_d;
   logic              deny_q, deny_d;
   logic              gate_q, gate_d;
   logic              err_q, err_d;

   logic [SPACES-1:0] set_mask;
   logic [SPACES-1:0] clr_mask_c;
   logic              exit_ok_c;
   logic [IDX_W-1:0]  alloc_idx_c;
   logic [FREE_W-1:0] free_cnt_c;
   logic              full_c;

   // Free-space count and full flag from the registered map
   always_comb begin
      free_cnt_c = '0;
      for (int i = 0; i < int'(SPACES); i++) begin
         if (!occ_q[i]) free_cnt_c = free_cnt_c + FREE_W'(1);
      end
      full_c = (free_cnt_c == '0);
   end

   // Lowest-index free space; codes at or above SPACES are never produced
   always_comb begin
      alloc_idx_c = '0;
      for (int i = int'(SPACES) - 1; i >= 0; i--) begin
         if (!occ_q[i]) alloc_idx_c = IDX_W'(i);
      end
   end

   // Exit decode: only an in-range, occupied space can be cleared
   always_comb begin
      clr_mask_c = '0;
      exit_ok_c  = 1'b0;
      for (int i = 0; i < int'(SPACES); i++) begin
         if (bus.exit_req && (bus.exit_space == IDX_W'(i)) && occ_q[i]) begin
            clr_mask_c[i] = 1'b1;
            exit_ok_c     = 1'b1;
         end
      end
   end

   // Next state, next occupancy and next registered outputs
   always_comb begin
      state_d  = state_q;
      park_d   = park_q;
      cnt_d    = cnt_q;
      set_mask = '0;

      case (state_q)
         IDLE: begin
            if (bus.entry_req) state_d = full_c ? DENY : ALLOC;
         end
         ALLOC: begin
            // Chooses from pre-exit occupancy so a space freed this cycle is not reused
            for (int i = 0; i < int'(SPACES); i++) begin
               if (alloc_idx_c == IDX_W'(i)) set_mask[i] = 1'b1;
            end
            park_d  = alloc_idx_c;
            cnt_d   = CNT_W'(GATE_CYCLES);
            state_d = GATE;
         end
         GATE: begin
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DENY: begin
            state_d = WAIT_REL;
         end
         WAIT_REL: begin
            if (!bus.entry_req) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      occ_d   = (occ_q & ~clr_mask_c) | set_mask;
      grant_d = (state_q == ALLOC);
      deny_d  = (state_d == DENY);
      gate_d  = (state_d == GATE);
      err_d   = bus.exit_req && !exit_ok_c;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         occ_q   <= '0;
         park_q  <= '0;
         cnt_q   <= '0;
         grant_q <= 1'b0;
         deny_q  <= 1'b0;
         gate_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         park_q  <= park_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         deny_q  <= deny_d;
         gate_q  <= gate_d;
         err_q   <= err_d;
      end
   end

   assign bus.entry_grant = grant_q;
   assign bus.entry_deny  = deny_q;
   assign bus.park_number = park_q;
   assign bus.gate_open   = gate_q;
   assign bus.occupancy   = occ_q;
   assign bus.free_count  = free_cnt_c;
   assign bus.full        = full_c;
   assign bus.exit_err    = err_q;

endmodule

// File: tb/tb_park_space_allocator.sv
// Bench for park_space_allocator: reference model plus directed scenarios.
module tb_park_space_allocator;

   localparam int unsigned SPACES = 8;
   localparam int unsigned GATE_N = 4;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   chk_en   = 0;

   park_space_allocator_if #(.SPACES(8), .IDX_W(3)) bus8 ();
   park_space_allocator_if #(.SPACES(6), .IDX_W(3)) bus6 ();

   park_space_allocator #(.SPACES(8), .IDX_W(3), .GATE_CYCLES(4)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8.slave)
   );

   park_space_allocator #(.SPACES(6), .IDX_W(3), .GATE_CYCLES(2)) u_dut6 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus6.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (8-space instance) ----------------
   bit [7:0] m_occ;
   int       m_park;
   bit       m_grant, m_deny, m_err;
   int       m_gate_left;
   bit       m_alloc_due, m_wait;
   bit [7:0] m_next;
   bit       m_was_deny;
   int       m_lo;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_occ = '0; m_park = 0; m_grant = 0; m_deny = 0; m_err = 0;
         m_gate_left = 0; m_alloc_due = 0; m_wait = 0;
      end else begin
         m_next = m_occ;
         m_err  = 0;
         if (bus8.exit_req) begin
            if (int'(bus8.exit_space) < SPACES && m_occ[bus8.exit_space]) m_next[bus8.exit_space] = 1'b0;
            else m_err = 1;
         end
         m_was_deny = m_deny;
         m_grant = 0;
         m_deny  = 0;
         if (m_alloc_due) begin
            m_lo = 0;
            while (m_lo < 8 && m_occ[m_lo]) m_lo++;
            m_next[m_lo] = 1'b1;
            m_park = m_lo;
            m_grant = 1;
            m_gate_left = GATE_N;
            m_alloc_due = 0;
         end else if (m_gate_left > 0) begin
            m_gate_left--;
         end else if (m_was_deny) begin
            m_wait = 1;
         end else if (m_wait) begin
            if (!bus8.entry_req) m_wait = 0;
         end else if (bus8.entry_req) begin
            if (m_occ == 8'hFF) m_deny = 1;
            else m_alloc_due = 1;
         end
         m_occ = m_next;
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         int fc;
         fc = 0;
         for (int i = 0; i < 8; i++) if (!m_occ[i]) fc++;
         check("occupancy",   64'(bus8.occupancy),   64'(m_occ));
         check("park_number", 64'(bus8.park_number), 64'(m_park));
         check("entry_grant", 64'(bus8.entry_grant), 64'(m_grant));
         check("entry_deny",  64'(bus8.entry_deny),  64'(m_deny));
         check("gate_open",   64'(bus8.gate_open),   64'(m_gate_left > 0));
         check("exit_err",    64'(bus8.exit_err),    64'(m_err));
         check("free_count",  64'(bus8.free_count),  64'(fc));
         check("full",        64'(bus8.full),        64'(fc == 0));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic do_entry(output int pn, output int lat, output int gcnt);
      bus8.entry_req = 1'b1;
      pn = -1; lat = 0; gcnt = 0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (bus8.entry_grant) begin
            pn = int'(bus8.park_number);
            lat = k;
            break;
         end
      end
      bus8.entry_req = 1'b0;
      if (pn < 0) begin
         check("grant_timeout", 64'd0, 64'd1);
         return;
      end
      for (int k = 0; k < 20; k++) begin
         if (!bus8.gate_open) break;
         gcnt++;
         tick();
      end
      tick();
   endtask

   int pn, lat, gc, dcnt;

   initial begin
      rst_n = 1'b0;
      bus8.entry_req = 0; bus8.exit_req = 0; bus8.exit_space = '0;
      bus6.entry_req = 0; bus6.exit_req = 0; bus6.exit_space = '0;
      #12;
      check("rst_occupancy", 64'(bus8.occupancy), 64'h0);
      check("rst_free",      64'(bus8.free_count), 64'd8);
      check("rst_gate",      64'(bus8.gate_open), 64'd0);
      rst_n = 1'b1;
      chk_en = 1;
      tick();

      // First entry after reset
      do_entry(pn, lat, gc);
      check("first_pn",      64'(pn),  64'd0);
      check("first_latency", 64'(lat), 64'd2);
      check("first_gate",    64'(gc),  64'd4);
      check("first_occ",     64'(bus8.occupancy), 64'h01);
      check("first_free",    64'(bus8.free_count), 64'd7);

      // Fill the lot
      for (int e = 1; e < 8; e++) begin
         do_entry(pn, lat, gc);
         check("fill_pn", 64'(pn), 64'(e));
      end
      check("fill_full", 64'(bus8.full), 64'd1);
      check("fill_free", 64'(bus8.free_count), 64'd0);

      // Ninth request: one deny while held
      bus8.entry_req = 1'b1;
      dcnt = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus8.entry_deny) dcnt++;
         if (bus8.entry_grant) check("deny_no_grant", 64'd1, 64'd0);
      end
      check("deny_count", 64'(dcnt), 64'd1);
      check("deny_occ",   64'(bus8.occupancy), 64'hFF);
      bus8.entry_req = 1'b0;
      tick(); tick();

      // Exit from space 3, then refill it
      bus8.exit_req = 1'b1; bus8.exit_space = 3'd3;
      tick();
      bus8.exit_req = 1'b0;
      check("exit3_occ",  64'(bus8.occupancy), 64'hF7);
      check("exit3_full", 64'(bus8.full), 64'd0);
      do_entry(pn, lat, gc);
      check("refill_pn", 64'(pn), 64'd3);

      // Exit coinciding with allocation
      pulse_reset();
      do_entry(pn, lat, gc);
      do_entry(pn, lat, gc);
      check("pre_sim_occ", 64'(bus8.occupancy), 64'h03);
      bus8.entry_req = 1'b1;
      tick();
      bus8.exit_req = 1'b1; bus8.exit_space = 3'd0;
      tick();
      bus8.exit_req = 1'b0; bus8.entry_req = 1'b0;
      check("sim_grant", 64'(bus8.entry_grant), 64'd1);
      check("sim_pn",    64'(bus8.park_number), 64'd2);
      check("sim_occ",   64'(bus8.occupancy), 64'h06);
      for (int k = 0; k < 20 && bus8.gate_open; k++) tick();
      tick();

      // Exit to a free space
      pulse_reset();
      do_entry(pn, lat, gc);
      bus8.exit_req = 1'b1; bus8.exit_space = 3'd5;
      tick();
      bus8.exit_req = 1'b0;
      check("free_exit_err", 64'(bus8.exit_err), 64'd1);
      check("free_exit_occ", 64'(bus8.occupancy), 64'h01);
      tick();
      check("free_exit_err_clr", 64'(bus8.exit_err), 64'd0);

      // Reset in gate cycle 2
      bus8.entry_req = 1'b1;
      tick(); tick();
      bus8.entry_req = 1'b0;
      check("mid_grant_pn", 64'(bus8.park_number), 64'd1);
      tick();
      check("mid_gate_open", 64'(bus8.gate_open), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async_gate", 64'(bus8.gate_open), 64'd0);
      check("async_occ",  64'(bus8.occupancy), 64'h0);
      check("async_free", 64'(bus8.free_count), 64'd8);
      #2;
      rst_n = 1'b1;
      tick();
      do_entry(pn, lat, gc);
      check("post_rst_pn", 64'(pn), 64'd0);

      // Six-space instance: fill, then out-of-range exits
      for (int e = 0; e < 6; e++) begin
         int got;
         got = -1;
         bus6.entry_req = 1'b1;
         for (int k = 0; k < 8; k++) begin
            tick();
            if (bus6.entry_grant) begin got = int'(bus6.park_number); break; end
         end
         bus6.entry_req = 1'b0;
         check("s6_pn", 64'(got), 64'(e));
         for (int k = 0; k < 10 && bus6.gate_open; k++) tick();
         tick();
      end
      check("s6_full", 64'(bus6.full), 64'd1);
      check("s6_occ",  64'(bus6.occupancy), 64'h3F);
      bus6.exit_req = 1'b1; bus6.exit_space = 3'd7;
      tick();
      check("s6_exit7_err", 64'(bus6.exit_err), 64'd1);
      bus6.exit_space = 3'd6;
      tick();
      check("s6_exit6_err", 64'(bus6.exit_err), 64'd1);
      check("s6_exit_occ",  64'(bus6.occupancy), 64'h3F);
      bus6.exit_space = 3'd5;
      tick();
      bus6.exit_req = 1'b0;
      check("s6_exit5_ok",  64'(bus6.exit_err), 64'd0);
      check("s6_exit5_occ", 64'(bus6.occupancy), 64'h1F);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
